fp_div_norm_seq: RTL and testbench



---
 rtl/fp_div_pkg.sv | 21 ++
 rtl/lzc_param.sv | 18 +
 rtl/fp_div_norm_seq.sv | 110 +++++++++++
 tb/tb_fp_div_norm_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the floating-point divider post-normalisation stage.
package fp_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_t;

  localparam int unsigned QUO_W_DEF  = 70;
  localparam int unsigned MANT_W_DEF = 23;
  localparam int unsigned EXP_W_DEF  = 10;
  localparam int unsigned STEP_DEF   = 4;

  // Offsets below the quotient MSB (the hidden bit) for each result field
  localparam int unsigned FRAC_OFS   = 2;
  localparam int unsigned GUARD_OFS  = 2;
  localparam int unsigned ROUND_OFS  = 3;
  localparam int unsigned STICKY_OFS = 4;

endpackage

// File: rtl/lzc_param.sv
// Combinational priority leading-zero counter; reports W for an all-zero input.
module lzc_param #(
  parameter int unsigned W  = 24,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_data,
  output logic [CW-1:0] o_cnt
);

  // Scan upward so the highest set bit wins
  always_comb begin
    o_cnt = CW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (i_data[i]) o_cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_div_norm_seq.sv
// Sequential post-divide normaliser: shifts the raw quotient left up to STEP bits
// per cycle and produces fraction, rounding bits and exponent adjustment.
module fp_div_norm_seq
  import fp_div_pkg::*;
#(
  parameter int unsigned QUO_W  = QUO_W_DEF,
  parameter int unsigned MANT_W = MANT_W_DEF,
  parameter int unsigned EXP_W  = EXP_W_DEF,
  parameter int unsigned STEP   = STEP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [QUO_W-1:0]  quotient,
  input  logic [MANT_W:0]   dividend_m,
  input  logic [MANT_W:0]   divisor_m,
  input  logic              a_denorm,
  input  logic              b_denorm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mant_out,
  output logic              guard,
  output logic              round_b,
  output logic              sticky,
  output logic [EXP_W-1:0]  exp_adj,
  output logic              zero
);

  localparam int unsigned MW      = MANT_W + 1;
  localparam int unsigned AW      = $clog2(MW + 1);
  localparam int unsigned SW      = $clog2(STEP + 1);
  localparam int unsigned ADJ_MAX = QUO_W + 2 * MW;

  if (STEP < 1 || STEP > 8 || QUO_W < MANT_W + 4 || (1 << (EXP_W - 1)) <= ADJ_MAX) begin : g_bad_param
    $error("fp_div_norm_seq: illegal parameter combination");
  end

  norm_state_t      r_state;
  logic [QUO_W-1:0] r_q;
  logic [EXP_W-1:0] r_adj;

  logic [AW-1:0]    w_lz_a;
  logic [AW-1:0]    w_lz_b;
  logic [SW-1:0]    w_lz_s;
  logic [STEP-1:0]  w_win;
  logic [EXP_W-1:0] w_adj_init;

  lzc_param #(.W(MW)) u_lzc_a (.i_data(dividend_m), .o_cnt(w_lz_a));
  lzc_param #(.W(MW)) u_lzc_b (.i_data(divisor_m),  .o_cnt(w_lz_b));
  lzc_param #(.W(STEP)) u_lzc_s (.i_data(w_win), .o_cnt(w_lz_s));

  assign w_win      = r_q[QUO_W-1 -: STEP];
  assign w_adj_init = (b_denorm ? EXP_W'(w_lz_b) : EXP_W'(0))
                    - (a_denorm ? EXP_W'(w_lz_a) : EXP_W'(0));
  assign in_ready   = (r_state == IDLE);

  // First DONE cycle captures the result fields; the second onward presents them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_q       <= '0;
      r_adj     <= '0;
      out_valid <= 1'b0;
      mant_out  <= '0;
      guard     <= 1'b0;
      round_b   <= 1'b0;
      sticky    <= 1'b0;
      exp_adj   <= '0;
      zero      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_q     <= quotient;
            r_adj   <= w_adj_init;
            r_state <= NORM;
          end
        end
        NORM: begin
          if (r_q == '0) begin
            zero    <= 1'b1;
            r_state <= DONE;
          end else if (r_q[QUO_W-1]) begin
            r_state <= DONE;
          end else begin
            r_q   <= r_q << w_lz_s;
            r_adj <= r_adj - EXP_W'(w_lz_s);
          end
        end
        DONE: begin
          if (!out_valid) begin
            mant_out  <= r_q[QUO_W-FRAC_OFS -: MANT_W];
            guard     <= r_q[QUO_W-GUARD_OFS-MANT_W];
            round_b   <= r_q[QUO_W-ROUND_OFS-MANT_W];
            sticky    <= |r_q[QUO_W-STICKY_OFS-MANT_W:0];
            exp_adj   <= r_adj;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            zero      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_norm_seq.sv
// Self-checking bench for fp_div_norm_seq against a bit-counting reference model.
module tb_fp_div_norm_seq;

  localparam int QW = 70;
  localparam int MW = 23;
  localparam int EW = 10;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [QW-1:0] quotient = '0;
  logic [MW:0]   dividend_m = '0;
  logic [MW:0]   divisor_m = '0;
  logic          a_denorm = 1'b0;
  logic          b_denorm = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [MW-1:0] mant_out;
  logic          guard;
  logic          round_b;
  logic          sticky;
  logic [EW-1:0] exp_adj;
  logic          zero;

  int checks = 0;
  int failures = 0;

  fp_div_norm_seq #(.QUO_W(QW), .MANT_W(MW), .EXP_W(EW), .STEP(ST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .quotient(quotient), .dividend_m(dividend_m), .divisor_m(divisor_m),
    .a_denorm(a_denorm), .b_denorm(b_denorm), .out_valid(out_valid),
    .out_ready(out_ready), .mant_out(mant_out), .guard(guard), .round_b(round_b),
    .sticky(sticky), .exp_adj(exp_adj), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [QW-1:0] obs, input logic [QW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leading zeros of the low w bits of v, counted from bit w-1
  function automatic int lz_n(input logic [QW-1:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) if (v[i]) return w - 1 - i;
    return w;
  endfunction

  task automatic run_txn(input string tag, input logic [QW-1:0] q, input logic [MW:0] dm,
                         input logic [MW:0] vm, input logic ad, input logic bd, input int hold);
    int lz, lat, adj, exp_lat;
    logic [QW-1:0] norm;
    logic [EW-1:0] exp_e;
    logic ez;
    lz  = lz_n(q, QW);
    adj = (bd ? lz_n(QW'(vm), MW + 1) : 0) - (ad ? lz_n(QW'(dm), MW + 1) : 0);
    if (q == '0) begin
      ez = 1'b1; norm = '0; exp_lat = 2;
    end else begin
      ez = 1'b0; norm = q << lz; adj = adj - lz; exp_lat = (lz + ST - 1) / ST + 2;
    end
    exp_e = EW'(adj);
    check({tag, " in_ready_idle"}, QW'(in_ready), QW'(1));
    quotient = q; dividend_m = dm; divisor_m = vm; a_denorm = ad; b_denorm = bd;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, QW'(lat), QW'(exp_lat));
    check({tag, " zero"}, QW'(zero), QW'(ez));
    check({tag, " mant_out"}, QW'(mant_out), QW'(norm[QW-2 -: MW]));
    check({tag, " guard"}, QW'(guard), QW'(norm[QW-2-MW]));
    check({tag, " round_b"}, QW'(round_b), QW'(norm[QW-3-MW]));
    check({tag, " sticky"}, QW'(sticky), QW'(|norm[QW-4-MW:0]));
    check({tag, " exp_adj"}, QW'(exp_adj), QW'(exp_e));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      quotient = {$urandom, $urandom, $urandom};
      @(posedge clk); #1;
      check({tag, " hold_valid"}, QW'(out_valid), QW'(1));
      check({tag, " hold_in_ready"}, QW'(in_ready), QW'(0));
      check({tag, " hold_mant"}, QW'(mant_out), QW'(norm[QW-2 -: MW]));
      check({tag, " hold_exp"}, QW'(exp_adj), QW'(exp_e));
      check({tag, " hold_sticky"}, QW'(sticky), QW'(|norm[QW-4-MW:0]));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " release_valid"}, QW'(out_valid), QW'(0));
    check({tag, " release_ready"}, QW'(in_ready), QW'(1));
    check({tag, " release_zero"}, QW'(zero), QW'(0));
  endtask

  initial begin
    logic [QW-1:0] rq;
    logic [QW-1:0] ones;
    int rlz;

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", QW'(out_valid), QW'(0));
    check("reset mant_out", QW'(mant_out), QW'(0));
    check("reset exp_adj", QW'(exp_adj), QW'(0));
    check("reset zero", QW'(zero), QW'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset in_ready", QW'(in_ready), QW'(1));

    run_txn("norm_msb", QW'(1) << 69, 24'h800000, 24'h800000, 1'b0, 1'b0, 0);
    run_txn("shift_441", (QW'(1) << 60) | QW'(1), 24'h800000, 24'h800000, 1'b0, 1'b0, 0);
    run_txn("zero_q", '0, 24'h800000, 24'h800000, 1'b0, 1'b0, 0);
    run_txn("b_denorm", QW'(1) << 69, 24'h800000, 24'h000001, 1'b0, 1'b1, 0);
    run_txn("a_denorm", QW'(1) << 69, 24'h400000, 24'h800000, 1'b1, 1'b0, 0);
    run_txn("backpress", (QW'(3) << 50) | QW'(5), 24'h000100, 24'h000003, 1'b1, 1'b1, 5);

    for (int t = 0; t < 20; t++) begin
      rq  = {$urandom, $urandom, $urandom};
      rlz = int'($urandom_range(0, QW));
      if (rlz == QW) rq = '0;
      else begin
        rq = rq >> rlz;
        rq[QW-1-rlz] = 1'b1;
      end
      run_txn("random", rq, 24'($urandom), 24'($urandom), 1'($urandom), 1'($urandom), t % 3);
    end

    ones = '1;
    run_txn("all_ones", ones, 24'h800000, 24'h000001, 1'b0, 1'b1, 0);

    // Reset while quotient=1 is still being shifted
    quotient = QW'(1); dividend_m = 24'h800000; divisor_m = 24'h800000;
    a_denorm = 1'b0; b_denorm = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", QW'(out_valid), QW'(0));
    check("midreset in_ready", QW'(in_ready), QW'(1));
    check("midreset mant_out", QW'(mant_out), QW'(0));
    check("midreset exp_adj", QW'(exp_adj), QW'(0));
    check("midreset sticky", QW'(sticky), QW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn("after_reset", QW'(1), 24'h800000, 24'h000004, 1'b0, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
